// File: rtl/polar_pkg.sv
// Shared polar-code definitions: default code size, frozen set and FSM state type.
// Used by the sequential encoder and by the decoders.
package polar_pkg;

   localparam int N = 8;
   localparam int LOG2N = $clog2(N);
   localparam logic [N-1:0] FROZEN_MASK = 8'b0001_0111;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ENC  = 2'd1,
      ST_OUT  = 2'd2
   } enc_state_t;

endpackage

// File: rtl/polar_butterfly_stage.sv
// One combinational XOR stage of the polar transform: x[i] ^= x[i+2^STAGE] where bit STAGE of i is 0.
// Encoder-side counterpart of the decoder partial-sum generator.
module polar_butterfly_stage #(
   parameter int N     = 8,
   parameter int STAGE = 0
) (
   input  logic [N-1:0] x_in,
   output logic [N-1:0] x_out
);

   localparam int SPAN = 1 << STAGE;

   for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> STAGE) & 1) == 0) begin : g_top
         assign x_out[i] = x_in[i] ^ x_in[i + SPAN];
      end else begin : g_pass
         assign x_out[i] = x_in[i];
      end
   end

endmodule

// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder: serial info bits fill non-frozen u positions, then one butterfly
// stage per cycle transforms u in place into x, held on cw until the sink takes it.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1; the source
// holds data while valid is high, info_ready is 1 only in LOAD, cw_valid is 1 only in OUT.
module polar_encoder_seq #(
   parameter int N = polar_pkg::N,
   parameter logic [N-1:0] FROZEN_MASK = polar_pkg::FROZEN_MASK
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  info_bit,
   input  logic                  info_valid,
   output logic                  info_ready,
   output logic [N-1:0]          cw,
   output logic                  cw_valid,
   input  logic                  cw_ready,
   output logic                  busy,
   output polar_pkg::enc_state_t state_dbg
);

   import polar_pkg::*;

   localparam int STAGES = $clog2(N);
   localparam int K_INFO = N - $countones(FROZEN_MASK);
   localparam int CNT_W  = $clog2(N + 1);
   localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [STG_W-1:0] STG_ONE = 1;

   enc_state_t       state, state_nxt;
   logic [N-1:0]     x_reg, x_nxt, load_sel;
   logic [CNT_W-1:0] cnt, cnt_nxt, seen;
   logic [STG_W-1:0] stage, stage_nxt;
   logic [N-1:0]     stage_out [STAGES];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      polar_butterfly_stage #(.N(N), .STAGE(s)) u_stage (
         .x_in  (x_reg),
         .x_out (stage_out[s])
      );
   end

   // One-hot slot for the next info bit: the cnt-th non-frozen index, counting upward.
   always_comb begin
      load_sel = '0;
      seen     = '0;
      for (int i = 0; i < N; i++) begin
         if (!FROZEN_MASK[i]) begin
            if (seen == cnt) load_sel[i] = 1'b1;
            seen = seen + CNT_ONE;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      x_nxt      = x_reg;
      cnt_nxt    = cnt;
      stage_nxt  = stage;
      info_ready = 1'b0;
      cw_valid   = 1'b0;
      case (state)
         ST_LOAD: begin
            info_ready = 1'b1;
            if (info_valid) begin
               x_nxt   = (x_reg & ~load_sel) | ({N{info_bit}} & load_sel);
               cnt_nxt = cnt + CNT_ONE;
               if (cnt == CNT_W'(K_INFO - 1)) begin
                  state_nxt = ST_ENC;
                  stage_nxt = '0;
               end
            end
         end
         ST_ENC: begin
            for (int s = 0; s < STAGES; s++) begin
               if (stage == STG_W'(s)) x_nxt = stage_out[s];
            end
            stage_nxt = stage + STG_ONE;
            if (stage == STG_W'(STAGES - 1)) begin
               state_nxt = ST_OUT;
               stage_nxt = '0;
            end
         end
         ST_OUT: begin
            cw_valid = 1'b1;
            if (cw_ready) begin
               state_nxt = ST_LOAD;
               x_nxt     = '0;
               cnt_nxt   = '0;
               stage_nxt = '0;
            end
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_LOAD;
         x_reg <= '0;
         cnt   <= '0;
         stage <= '0;
      end else begin
         state <= state_nxt;
         x_reg <= x_nxt;
         cnt   <= cnt_nxt;
         stage <= stage_nxt;
      end
   end

   assign cw        = x_reg;
   assign busy      = (state != ST_LOAD) || (cnt != '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_polar_encoder_seq.sv
// Bench for polar_encoder_seq (N=8, default frozen set): directed vector table, stall and reset
// sequences, then random messages against a generator-matrix model and a hard-decision decode.
module tb_polar_encoder_seq;
   import polar_pkg::*;

   localparam logic [7:0] FROZEN = 8'b0001_0111;

   logic       clk = 1'b0;
   logic       rst, info_bit, info_valid, cw_ready;
   logic       info_ready, cw_valid, busy;
   logic [7:0] cw;
   enc_state_t state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [3:0] msg;
      logic [7:0] exp_cw;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   polar_encoder_seq #(.N(8), .FROZEN_MASK(FROZEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .info_bit   (info_bit),
      .info_valid (info_valid),
      .info_ready (info_ready),
      .cw         (cw),
      .cw_valid   (cw_valid),
      .cw_ready   (cw_ready),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // Reference: u from message (ascending non-frozen slots), x_j = XOR of u_i over i whose bits cover j.
   function automatic logic [7:0] model_cw(input logic [3:0] msg);
      logic [7:0] u, x;
      int k;
      u = '0; x = '0; k = 0;
      for (int i = 0; i < 8; i++) begin
         if (!FROZEN[i]) begin
            u[i] = msg[k];
            k++;
         end
      end
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < 8; i++)
            if ((i & j) == j) x[j] ^= u[i];
      return x;
   endfunction

   // The transform is its own inverse over GF(2).
   function automatic logic [7:0] decode_u(input logic [7:0] x);
      logic [7:0] u;
      u = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if ((j & i) == i) u[i] ^= x[j];
      return u;
   endfunction

   function automatic logic [3:0] extract_msg(input logic [7:0] u);
      logic [3:0] m;
      int k;
      m = '0; k = 0;
      for (int i = 0; i < 8; i++) begin
         if (!FROZEN[i]) begin
            m[k] = u[i];
            k++;
         end
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; info_valid = 1'b0; info_bit = 1'b0; cw_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      int waited;
      waited = 0;
      info_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         info_bit = 1'($urandom_range(0, 1));
         cw_ready = 1'($urandom_range(0, 1));
         tick();
      end
      info_valid = 1'b1;
      info_bit   = b;
      cw_ready   = 1'($urandom_range(0, 1));
      while (!info_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!info_ready) check("ready_timeout", {31'd0, info_ready}, 32'd1);
      else tick();
      info_valid = 1'b0;
   endtask

   // Sends 4 bits, then checks cw_valid rises exactly 3 edges after the last accept.
   task automatic send_msg(input logic [3:0] msg, input int gap_max);
      for (int k = 0; k < 4; k++) send_bit(msg[k], $urandom_range(0, gap_max));
      for (int c = 1; c <= 3; c++) begin
         info_valid = 1'($urandom_range(0, 1));
         info_bit   = 1'($urandom_range(0, 1));
         if (c < 3) cw_ready = 1'($urandom_range(0, 1));
         tick();
         check("latency_valid", {31'd0, cw_valid}, (c == 3) ? 32'd1 : 32'd0);
         check("enc_busy", {31'd0, busy}, 32'd1);
      end
      cw_ready = 1'b0;
      check("out_info_ready", {31'd0, info_ready}, 32'd0);
   endtask

   task automatic drain(input int stall);
      logic [7:0] exp;
      logic [7:0] u;
      int waited;
      waited = 0;
      exp = exp_q.pop_front();
      while (!cw_valid && waited < 20) begin
         tick();
         waited++;
      end
      check("cw_valid_wait", {31'd0, cw_valid}, 32'd1);
      for (int s = 0; s < stall; s++) begin
         cw_ready   = 1'b0;
         info_valid = 1'($urandom_range(0, 1));
         info_bit   = 1'($urandom_range(0, 1));
         tick();
         check("stall_cw", {24'd0, cw}, {24'd0, exp});
         check("stall_valid", {31'd0, cw_valid}, 32'd1);
         check("stall_info_ready", {31'd0, info_ready}, 32'd0);
      end
      check("cw", {24'd0, cw}, {24'd0, exp});
      u = decode_u(cw);
      check("dec_frozen", {24'd0, u & FROZEN}, 32'd0);
      check("dec_msg", {28'd0, extract_msg(u)}, {28'd0, extract_msg(decode_u(exp))});
      cw_ready   = 1'b1;
      info_valid = 1'($urandom_range(0, 1));
      tick();
      cw_ready   = 1'b0;
      info_valid = 1'b0;
      check("post_valid", {31'd0, cw_valid}, 32'd0);
      check("post_info_ready", {31'd0, info_ready}, 32'd1);
      check("post_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] m;
      vecs[0] = '{4'b0001, 8'h0F};
      vecs[1] = '{4'b1000, 8'hFF};
      vecs[2] = '{4'b1111, 8'h96};
      vecs[3] = '{4'b0010, 8'h33};
      vecs[4] = '{4'b0100, 8'h55};
      vecs[5] = '{4'b0000, 8'h00};

      do_reset();
      check("rst_cw", {24'd0, cw}, 32'd0);
      check("rst_valid", {31'd0, cw_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_info_ready", {31'd0, info_ready}, 32'd1);
      check("rst_state", 32'(state_dbg), 32'(ST_LOAD));

      foreach (vecs[v]) begin
         send_msg(vecs[v].msg, 0);
         exp_q.push_back(vecs[v].exp_cw);
         drain(0);
      end

      // Long sink stall
      send_msg(4'b1111, 0);
      exp_q.push_back(8'h96);
      drain(10);

      // Reset after two accepted bits discards them
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      check("partial_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #2;
      check("async_cw", {24'd0, cw}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      check("rel_info_ready", {31'd0, info_ready}, 32'd1);
      send_msg(4'b0001, 0);
      exp_q.push_back(8'h0F);
      drain(0);

      // Reset mid-encode produces no output
      for (int k = 0; k < 4; k++) send_bit(1'b1, 0);
      tick();
      rst = 1'b1;
      #2;
      check("enc_rst_valid", {31'd0, cw_valid}, 32'd0);
      check("enc_rst_state", 32'(state_dbg), 32'(ST_LOAD));
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("enc_rst_quiet", {31'd0, cw_valid}, 32'd0);
      end

      // Random messages with random gaps and stalls
      for (int t = 0; t < 1000; t++) begin
         m = 4'($urandom_range(0, 15));
         send_msg(m, 2);
         exp_q.push_back(model_cw(m));
         drain($urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
